// File: rtl/bcd_multi_speed_cnt_if.sv
// Control/data bundle for the multi-digit BCD counter.
// Master drives controls and load data; slave returns count and tc.
interface bcd_multi_speed_cnt_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  sel;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   y;
  logic                  tc;

  modport master (
    output en, sel, up, load, load_val,
    input  y, tc
  );

  modport slave (
    input  en, sel, up, load, load_val,
    output y, tc
  );
endinterface

// File: rtl/bcd_multi_speed_cnt.sv
// Multi-digit BCD up/down counter with fast/slow speed,
// parallel load (digits clamped to 9) and a wrap pulse.
module bcd_multi_speed_cnt #(
  parameter int DIGITS   = 2,
  parameter int SLOW_DIV = 2
) (
  input logic              clk,
  input logic              rst,
  bcd_multi_speed_cnt_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(SLOW_DIV);
  localparam logic [PW-1:0] PMAX = PW'(SLOW_DIV - 1);

  logic [W-1:0]  r_y;
  logic          r_tc;
  logic [PW-1:0] r_pre;

  logic [W-1:0]  w_step;
  logic [W-1:0]  w_ld;
  logic          w_wrap;
  logic          w_tick;
  logic [PW-1:0] w_pre_nxt;

  // Ripple one +/-1 step through the digits; carry out means wrap.
  always_comb begin : p_step
    logic       c;
    logic [3:0] d;
    c      = 1'b1;
    d      = 4'd0;
    w_step = r_y;
    for (int i = 0; i < DIGITS; i++) begin
      d = r_y[4*i +: 4];
      if (c) begin
        if (bus.up) begin
          if (d >= 4'd9) begin
            w_step[4*i +: 4] = 4'd0;
          end else begin
            w_step[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            w_step[4*i +: 4] = 4'd9;
          end else begin
            w_step[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    w_wrap = c;
  end

  // Saturate each loaded digit to 9 so y stays valid BCD.
  always_comb begin : p_clamp
    w_ld = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        w_ld[4*i +: 4] = 4'd9;
      end else begin
        w_ld[4*i +: 4] = bus.load_val[4*i +: 4];
      end
    end
  end

  // Prescaler: parked at 0 in fast mode, frozen when disabled.
  always_comb begin : p_pre
    w_pre_nxt = r_pre;
    if (bus.sel) begin
      w_pre_nxt = '0;
    end else if (bus.en) begin
      if (r_pre == PMAX) begin
        w_pre_nxt = '0;
      end else begin
        w_pre_nxt = r_pre + PW'(1);
      end
    end
  end

  assign w_tick = bus.en & (bus.sel | (r_pre == PMAX));

  // State update: reset > load > count > hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y   <= '0;
      r_tc  <= 1'b0;
      r_pre <= '0;
    end else if (bus.load) begin
      r_y   <= w_ld;
      r_tc  <= 1'b0;
      r_pre <= '0;
    end else begin
      r_pre <= w_pre_nxt;
      r_tc  <= w_tick & w_wrap;
      if (w_tick) begin
        r_y <= w_step;
      end
    end
  end

  assign bus.y  = r_y;
  assign bus.tc = r_tc;
endmodule
